// File: rtl/spif_pkg.sv
// rtl/spif_pkg.sv - shared state encoding, port indices, defaults and saturating helpers for spif_arbiter
package spif_pkg;

    // Session state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPEN = 2'd1,
        ST_XFER = 2'd2,
        ST_CSH  = 2'd3
    } spif_state_e;

    // Owner index values carried in the owner register
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Parameter defaults
    localparam int CSH_CYCLES_DEF = 4;
    localparam int TIMEOUT_DEF    = 65535;

    // Counters saturate instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'd0) ? v : v - 8'd1;
    endfunction

endpackage

// File: rtl/spif_arbiter.sv
// rtl/spif_arbiter.sv - two-port SPI flash session arbiter in front of an external byte shifter
//
// Ports:
//   clk_in, rst_n                 clock, asynchronous active-low reset
//   a_req/a_go/a_tx               port A session request, byte strobe, byte to send
//   a_gnt/a_ready/a_rvalid        port A owns session, may strobe go, received byte pulse
//   b_*                           same set for port B (fixed priority, never preempts)
//   rdata                         last received byte, shared by both ports
//   spi_go/spi_tx                 start pulse and byte to the external shifter
//   spi_done/spi_rx               completion pulse and received byte from the shifter
//   spi_csn                       flash chip select, active low
module spif_arbiter
    import spif_pkg::*;
#(
    parameter int CSH_CYCLES = CSH_CYCLES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_go,
    input  logic [7:0] a_tx,
    output logic       a_gnt,
    output logic       a_ready,
    output logic       a_rvalid,
    input  logic       b_req,
    input  logic       b_go,
    input  logic [7:0] b_tx,
    output logic       b_gnt,
    output logic       b_ready,
    output logic       b_rvalid,
    output logic [7:0] rdata,
    output logic       spi_go,
    output logic [7:0] spi_tx,
    input  logic       spi_done,
    input  logic [7:0] spi_rx,
    output logic       spi_csn
);

    localparam logic [7:0]  CSH_LOAD  = 8'(CSH_CYCLES);
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
    localparam bit          TMO_EN    = (TIMEOUT != 0);

    spif_state_e state_q, state_d;
    logic        owner_q, owner_d;
    logic        a_gnt_q, a_gnt_d;
    logic        b_gnt_q, b_gnt_d;
    logic        a_ready_q, a_ready_d;
    logic        b_ready_q, b_ready_d;
    logic        a_rvalid_q, a_rvalid_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        spi_go_q, spi_go_d;
    logic [7:0]  spi_tx_q, spi_tx_d;
    logic        spi_csn_q, spi_csn_d;
    logic [7:0]  csh_cnt_q, csh_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    // Set by a timeout release; the port cannot be granted again until its req is seen low
    logic        a_lock_q, a_lock_d;
    logic        b_lock_q, b_lock_d;

    // Current owner's view of the port inputs
    logic        owner_req;
    logic        owner_go;
    logic        owner_ready;
    logic [7:0]  owner_tx;
    logic [15:0] tmo_inc;
    logic        tmo_hit;
    logic        do_release;

    assign owner_req   = (owner_q == PORT_B) ? b_req     : a_req;
    assign owner_go    = (owner_q == PORT_B) ? b_go      : a_go;
    assign owner_ready = (owner_q == PORT_B) ? b_ready_q : a_ready_q;
    assign owner_tx    = (owner_q == PORT_B) ? b_tx      : a_tx;
    assign tmo_inc     = sat_inc16(tmo_cnt_q);
    assign tmo_hit     = TMO_EN && (tmo_inc >= TMO_LIMIT);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        a_gnt_d    = a_gnt_q;
        b_gnt_d    = b_gnt_q;
        a_ready_d  = a_ready_q;
        b_ready_d  = b_ready_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        rdata_d    = rdata_q;
        spi_go_d   = 1'b0;
        spi_tx_d   = spi_tx_q;
        spi_csn_d  = spi_csn_q;
        csh_cnt_d  = csh_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        a_lock_d   = a_lock_q & a_req;
        b_lock_d   = b_lock_q & b_req;
        do_release = 1'b0;

        case (state_q)
            ST_IDLE: begin
                spi_csn_d = 1'b1;
                if (b_req && !b_lock_q) begin
                    owner_d   = PORT_B;
                    b_gnt_d   = 1'b1;
                    b_ready_d = 1'b1;
                    spi_csn_d = 1'b0;
                    tmo_cnt_d = 16'd0;
                    state_d   = ST_OPEN;
                end else if (a_req && !a_lock_q) begin
                    owner_d   = PORT_A;
                    a_gnt_d   = 1'b1;
                    a_ready_d = 1'b1;
                    spi_csn_d = 1'b0;
                    tmo_cnt_d = 16'd0;
                    state_d   = ST_OPEN;
                end
            end

            ST_OPEN: begin
                // A dropped request wins over a same-cycle go
                if (!owner_req) begin
                    do_release = 1'b1;
                end else if (owner_go && owner_ready) begin
                    spi_go_d  = 1'b1;
                    spi_tx_d  = owner_tx;
                    a_ready_d = 1'b0;
                    b_ready_d = 1'b0;
                    tmo_cnt_d = 16'd0;
                    state_d   = ST_XFER;
                end else if (tmo_hit) begin
                    do_release = 1'b1;
                    if (owner_q == PORT_B) begin
                        b_lock_d = 1'b1;
                    end else begin
                        a_lock_d = 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end

            ST_XFER: begin
                if (spi_done) begin
                    rdata_d = spi_rx;
                    if (owner_q == PORT_B) begin
                        b_rvalid_d = 1'b1;
                    end else begin
                        a_rvalid_d = 1'b1;
                    end
                    // The byte always completes; a request dropped meanwhile releases here
                    if (owner_req) begin
                        if (owner_q == PORT_B) begin
                            b_ready_d = 1'b1;
                        end else begin
                            a_ready_d = 1'b1;
                        end
                        tmo_cnt_d = 16'd0;
                        state_d   = ST_OPEN;
                    end else begin
                        do_release = 1'b1;
                    end
                end
            end

            ST_CSH: begin
                if (csh_cnt_q <= 8'd1) begin
                    csh_cnt_d = 8'd0;
                    state_d   = ST_IDLE;
                end else begin
                    csh_cnt_d = sat_dec8(csh_cnt_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_release) begin
            spi_csn_d = 1'b1;
            a_gnt_d   = 1'b0;
            b_gnt_d   = 1'b0;
            a_ready_d = 1'b0;
            b_ready_d = 1'b0;
            csh_cnt_d = CSH_LOAD;
            tmo_cnt_d = 16'd0;
            state_d   = ST_CSH;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= PORT_A;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            rdata_q    <= 8'd0;
            spi_go_q   <= 1'b0;
            spi_tx_q   <= 8'd0;
            spi_csn_q  <= 1'b1;
            csh_cnt_q  <= 8'd0;
            tmo_cnt_q  <= 16'd0;
            a_lock_q   <= 1'b0;
            b_lock_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_ready_q  <= a_ready_d;
            b_ready_q  <= b_ready_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            rdata_q    <= rdata_d;
            spi_go_q   <= spi_go_d;
            spi_tx_q   <= spi_tx_d;
            spi_csn_q  <= spi_csn_d;
            csh_cnt_q  <= csh_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            a_lock_q   <= a_lock_d;
            b_lock_q   <= b_lock_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_ready  = a_ready_q;
    assign b_ready  = b_ready_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign rdata    = rdata_q;
    assign spi_go   = spi_go_q;
    assign spi_tx   = spi_tx_q;
    assign spi_csn  = spi_csn_q;

endmodule

// File: tb/tb_spif_arbiter.sv
// tb/tb_spif_arbiter.sv - self-checking bench for spif_arbiter
module tb_spif_arbiter;

    localparam int MD_CSH = 4;
    localparam int MD_TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       a_req = 1'b0, a_go = 1'b0, b_req = 1'b0, b_go = 1'b0;
    logic [7:0] a_tx = 8'd0, b_tx = 8'd0, spi_rx = 8'd0;
    logic       spi_done = 1'b0;
    logic       a_gnt, a_ready, a_rvalid, b_gnt, b_ready, b_rvalid;
    logic [7:0] rdata, spi_tx;
    logic       spi_go, spi_csn;

    always #5 clk = ~clk;

    spif_arbiter #(.CSH_CYCLES(MD_CSH), .TIMEOUT(MD_TMO)) dut (
        .clk_in(clk), .rst_n(rst_n),
        .a_req(a_req), .a_go(a_go), .a_tx(a_tx),
        .a_gnt(a_gnt), .a_ready(a_ready), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_go(b_go), .b_tx(b_tx),
        .b_gnt(b_gnt), .b_ready(b_ready), .b_rvalid(b_rvalid),
        .rdata(rdata), .spi_go(spi_go), .spi_tx(spi_tx),
        .spi_done(spi_done), .spi_rx(spi_rx), .spi_csn(spi_csn)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Session-level model: who owns the flash, whether a byte is in flight,
    // how many chip-select-high cycles remain, idle time, lockouts.
    int         m_owner = -1;
    bit         m_busy = 1'b0;
    int         m_gap = 0;
    int         m_idle = 0;
    bit         m_lock [2] = '{1'b0, 1'b0};
    logic [1:0] e_rv = 2'b00;
    logic       e_go = 1'b0;
    logic [7:0] e_tx = 8'd0, e_rd = 8'd0;
    logic [1:0] req_v, go_v;
    logic [7:0] tx_v [2];

    task automatic m_close();
        m_owner = -1;
        m_gap   = MD_CSH;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owner = -1; m_busy = 1'b0; m_gap = 0; m_idle = 0;
            m_lock = '{1'b0, 1'b0};
            e_rv = 2'b00; e_go = 1'b0; e_tx = 8'd0; e_rd = 8'd0;
        end else begin
            req_v = {b_req, a_req};
            go_v  = {b_go, a_go};
            tx_v[0] = a_tx;
            tx_v[1] = b_tx;
            e_go = 1'b0;
            e_rv = 2'b00;
            for (int p = 0; p < 2; p++) if (!req_v[p]) m_lock[p] = 1'b0;
            if (m_owner < 0) begin
                if (m_gap > 0) m_gap--;
                else if (req_v[1] && !m_lock[1]) begin m_owner = 1; m_idle = 0; end
                else if (req_v[0] && !m_lock[0]) begin m_owner = 0; m_idle = 0; end
            end else if (m_busy) begin
                if (spi_done) begin
                    e_rd = spi_rx;
                    e_rv[m_owner] = 1'b1;
                    m_busy = 1'b0;
                    if (!req_v[m_owner]) m_close();
                end
            end else if (!req_v[m_owner]) begin
                m_close();
            end else if (go_v[m_owner]) begin
                e_go = 1'b1;
                e_tx = tx_v[m_owner];
                m_busy = 1'b1;
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle >= MD_TMO) begin
                    m_lock[m_owner] = 1'b1;
                    m_close();
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("spi_csn",  int'(spi_csn),  int'(m_owner < 0));
            cmp("a_gnt",    int'(a_gnt),    int'(m_owner == 0));
            cmp("b_gnt",    int'(b_gnt),    int'(m_owner == 1));
            cmp("a_ready",  int'(a_ready),  int'(m_owner == 0 && !m_busy));
            cmp("b_ready",  int'(b_ready),  int'(m_owner == 1 && !m_busy));
            cmp("a_rvalid", int'(a_rvalid), int'(e_rv[0]));
            cmp("b_rvalid", int'(b_rvalid), int'(e_rv[1]));
            cmp("spi_go",   int'(spi_go),   int'(e_go));
            cmp("spi_tx",   int'(spi_tx),   int'(e_tx));
            cmp("rdata",    int'(rdata),    int'(e_rd));
        end
    end

    // Received-byte capture and chip-select integrity monitor
    logic [7:0] a_rx [$];
    logic [7:0] b_rx [$];
    int csn_glitch = 0;
    initial forever begin
        @(negedge clk);
        if (a_rvalid) a_rx.push_back(rdata);
        if (b_rvalid) b_rx.push_back(rdata);
        if ((a_gnt || b_gnt) && spi_csn) csn_glitch++;
    end

    task automatic xfer(input bit port, input logic [7:0] tx, input logic [7:0] rx);
        int n = 0;
        while (!(port ? b_ready : a_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmp("xfer_ready_wait", n < 40 ? 1 : 0, 1);
        if (port) begin b_go = 1'b1; b_tx = tx; end
        else      begin a_go = 1'b1; a_tx = tx; end
        @(negedge clk);
        a_go = 1'b0; b_go = 1'b0;
        @(negedge clk);
        spi_done = 1'b1; spi_rx = rx;
        @(negedge clk);
        spi_done = 1'b0;
    endtask

    task automatic wait_gnt(input bit port, input string nm);
        int n = 0;
        while (!(port ? b_gnt : a_gnt) && n < 60) begin
            @(negedge clk);
            n++;
        end
        cmp(nm, int'(port ? b_gnt : a_gnt), 1);
    endtask

    logic [7:0] boot_tx [8] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] boot_rx [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h11, 8'h12, 8'h13, 8'h14};
    logic [7:0] jd_rx   [4] = '{8'h00, 8'h01, 8'h60, 8'h17};

    initial begin
        int cnt;
        int hi;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        cmp("rst_csn", int'(spi_csn), 1);
        cmp("rst_gnt", int'({a_gnt, b_gnt, a_ready, b_ready}), 0);
        cmp("rst_data", int'({spi_go, spi_tx, rdata}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Boot read on port A
        a_req = 1'b1;
        wait_gnt(1'b0, "boot_gnt");
        for (int i = 0; i < 8; i++) xfer(1'b0, boot_tx[i], boot_rx[i]);
        a_req = 1'b0;
        repeat (8) @(negedge clk);
        cmp("boot_rvalid_count", a_rx.size(), 8);
        for (int i = 4; i < 8; i++) cmp("boot_rdata", int'(a_rx[i]), int'(boot_rx[i]));
        cmp("boot_csn_low", csn_glitch, 0);
        a_rx.delete();

        // Contention + JDID on port B
        a_req = 1'b1; b_req = 1'b1;
        @(negedge clk); @(negedge clk);
        cmp("cont_b_gnt", int'(b_gnt), 1);
        cmp("cont_a_gnt", int'(a_gnt), 0);
        xfer(1'b1, 8'h9F, jd_rx[0]);
        for (int i = 1; i < 4; i++) xfer(1'b1, 8'h00, jd_rx[i]);
        @(negedge clk);
        cmp("jdid_count", b_rx.size(), 4);
        for (int i = 1; i < 4; i++) cmp("jdid_rdata", int'(b_rx[i]), int'(jd_rx[i]));
        cmp("jdid_a_rvalid", a_rx.size(), 0);
        b_req = 1'b0;
        cnt = 0; hi = 0;
        while (!a_gnt && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (spi_csn) hi++;
        end
        cmp("cont_a_after_gap", int'(a_gnt), 1);
        cmp("csh_plus_idle_cycles", hi, MD_CSH + 1);

        // No preemption; stray b_go and spi_done are ignored
        b_req = 1'b1;
        b_go = 1'b1; b_tx = 8'h5A;
        @(negedge clk);
        b_go = 1'b0;
        spi_done = 1'b1; spi_rx = 8'hEE;
        @(negedge clk);
        spi_done = 1'b0;
        repeat (3) @(negedge clk);
        cmp("nopre_a_gnt", int'(a_gnt), 1);
        cmp("nopre_b_gnt", int'(b_gnt), 0);
        a_req = 1'b0;
        wait_gnt(1'b1, "nopre_b_after");
        b_req = 1'b0;
        repeat (8) @(negedge clk);

        // Timeout and lockout
        a_req = 1'b1;
        wait_gnt(1'b0, "tmo_gnt");
        cnt = 0;
        while (!spi_csn && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        cmp("tmo_low_cycles", cnt, MD_TMO);
        cmp("tmo_a_gnt", int'(a_gnt), 0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_gnt) cnt++;
        end
        cmp("tmo_no_regrant", cnt, 0);
        a_req = 1'b0;
        @(negedge clk);
        a_req = 1'b1;
        wait_gnt(1'b0, "tmo_regrant");
        a_req = 1'b0;
        repeat (8) @(negedge clk);

        // Reset in the middle of a transfer
        a_rx.delete();
        a_req = 1'b1;
        wait_gnt(1'b0, "rstx_gnt");
        a_go = 1'b1; a_tx = 8'hA5;
        @(negedge clk);
        a_go = 1'b0;
        cmp("rstx_spi_go", int'(spi_go), 1);
        #2 rst_n = 1'b0;
        #1;
        cmp("rstx_csn_async", int'(spi_csn), 1);
        cmp("rstx_gnt_async", int'(a_gnt), 0);
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spi_done = 1'b1; spi_rx = 8'hAA;
        @(negedge clk);
        spi_done = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rstx_late_done", a_rx.size(), 0);
        cmp("rstx_rdata", int'(rdata), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/spif_arbiter.md
SPIF_ARBITER -- requirements
Module: spif_arbiter

Interface
REQ-001 Parameter CSH_CYCLES, default 4: minimum clk_in cycles spi_csn stays high between sessions, legal range 1..255.
REQ-002 Parameter TIMEOUT, default 65535: cycles a granted owner may sit idle before forced release; 0 disables the timeout.
REQ-003 clk_in  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 a_req  in  1  port A (CPU/boot engine) requests, and then holds, a flash session.
REQ-006 a_go  in  1  port A byte-transfer strobe, one cycle.
REQ-007 a_tx  in  8  port A transmit byte, sampled with a_go.
REQ-008 a_gnt  out  1  port A owns the session.
REQ-009 a_ready  out  1  port A may assert a_go this cycle.
REQ-010 a_rvalid  out  1  one-cycle pulse: rdata holds port A's received byte.
REQ-011 b_req, b_go, b_tx, b_gnt, b_ready, b_rvalid  as A, for port B (UART ISP bridge).
REQ-012 rdata  out  8  last received byte, shared by both ports.
REQ-013 spi_go  out  1  one-cycle start to the external SPI byte shifter.
REQ-014 spi_tx  out  8  byte to shift, valid with spi_go.
REQ-015 spi_done  in  1  one-cycle pulse from the shifter: spi_rx is valid.
REQ-016 spi_rx  in  8  byte received by the shifter.
REQ-017 spi_csn  out  1  flash chip select, active low.

Function
REQ-018 The state machine SHALL have four states: IDLE, OPEN, XFER, CSH.
REQ-019 IDLE: with spi_csn=1 and both gnt=0, on the next edge B wins if b_req=1, otherwise A wins if a_req=1; the winner's gnt=1 and the state goes to OPEN.
REQ-020 Port B has fixed priority, but it SHALL never preempt an open session.
REQ-021 spi_csn SHALL go 0 on the same edge that enters OPEN and stay 0 through OPEN and XFER.
REQ-022 OPEN: the owner's ready is 1 and the other port's ready is 0. An owner go produces spi_go=1 and spi_tx=owner tx on the next cycle, ready drops, and the state goes to XFER.
REQ-023 go from a non-owner, or go while ready=0, SHALL be ignored, with no queuing.
REQ-024 XFER: on spi_done, rdata<=spi_rx and the owner's rvalid pulses on the next cycle; the state returns to OPEN and ready rises in that same cycle.
REQ-025 When the owner's req=0 in OPEN: spi_csn<=1, gnt<=0, the CSH counter loads CSH_CYCLES, and the state goes to CSH.
REQ-026 When req drops during XFER, the byte completes, its rvalid still pulses, and the block then releases as in REQ-025.
REQ-027 CSH: the counter decrements to 0, then the state goes to IDLE. Requests arriving during CSH wait, and are arbitrated in IDLE by REQ-019.
REQ-028 Idle timeout counts OPEN cycles with no go. When it reaches TIMEOUT, the block SHALL force release as in REQ-025, even if req=1.
REQ-029 After a timeout, the block SHALL hold that port's gnt=0 until its req has been seen low at least once.
REQ-030 A spi_done outside XFER SHALL be ignored.
REQ-031 Counters are 8-bit (CSH) and 16-bit (timeout) and SHALL saturate, never wrap.

Reset
REQ-032 While rst_n=0: state=IDLE, spi_csn=1, spi_go=0, spi_tx=0, rdata=0, all gnt/ready/rvalid=0, counters=0, timeout lockouts cleared.
REQ-033 Reset asserted mid-XFER SHALL force spi_csn=1 immediately (asynchronously); an in-flight spi_done after release SHALL be ignored per REQ-030.

Structure
REQ-034 State encodings, port index constants, and CSH_CYCLES/TIMEOUT defaults SHALL live in a shared package, spif_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the SPI byte shifter is external.

Verification
REQ-036 Boot read: a_req=1, go with tx 03h, 00h, 00h, 00h, then 4 dummy bytes (spi_rx=11h..14h), then a_req=0 -> spi_csn low for the whole session, 8 a_rvalid pulses with rdata 11h..14h on the last four, then spi_csn high for exactly 4 cycles before IDLE.
REQ-037 Contention: a_req and b_req rise in the same cycle -> b_gnt=1; a is granted only after b_req drops and 4 CSH cycles have elapsed.
REQ-038 No preemption: A holds a session and b_req rises -> a_gnt is unchanged; b_gnt follows A's release and CSH.
REQ-039 ISP JDID: b sends 9Fh then 3 dummy bytes with spi_rx=01h,60h,17h -> b_rvalid pulses carry 01h,60h,17h on the last three; a_rvalid stays 0.
REQ-040 Timeout with TIMEOUT=16: A granted, no go for 16 cycles -> spi_csn=1, a_gnt=0; a_req held 1 -> no regrant; a_req toggled low then high -> regranted.
REQ-041 Reset mid-XFER: rst_n=0 -> spi_csn=1 in the same cycle; after release, outputs match REQ-032 and a late spi_done produces no rvalid.
